// File: rtl/rr_arb2_stage.sv
// Two-input round-robin arbiter feeding a registered single-entry output stage.
// out_src carries the winning source and serves as the select for a downstream 2:1 mux.
module rr_arb2_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic             dbg_state,
  output logic             dbg_last_grant
);

  // Valid/ready: a word moves on a rising clk edge where both valid and ready
  // are high. A source holds valid and data stable until it sees ready. Readies
  // depend combinationally on the valids and on out_ready, and never on data.

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             last_grant_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_src_q;

  logic             any_valid;
  logic             grant;
  logic             load_en;
  logic             accept;
  logic [WIDTH-1:0] win_data;

  // When both sources are valid, the source that did not win the last
  // accepted transfer gets the grant.
  always_comb begin
    any_valid = in0_valid | in1_valid;
    grant     = 1'b0;
    if (in0_valid && in1_valid) begin
      grant = ~last_grant_q;
    end else if (in1_valid) begin
      grant = 1'b1;
    end
  end

  always_comb begin
    load_en   = (state_q == EMPTY) || out_ready;
    // Hold both readies low while reset is asserted so that nothing is
    // accepted during reset.
    in0_ready = ~rst & load_en & in0_valid & ~grant;
    in1_ready = ~rst & load_en & in1_valid &  grant;
    accept    = (in0_ready | in1_ready) & any_valid;
    win_data  = grant ? in1_data : in0_data;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (accept) state_d = FULL;
      end
      FULL: begin
        if (accept)         state_d = FULL;
        else if (out_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // The data register and last_grant change only on an accepted transfer. A
  // drain to empty leaves the last word in out_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q   <= '0;
      out_src_q    <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (accept) begin
      out_data_q   <= win_data;
      out_src_q    <= grant;
      last_grant_q <= grant;
    end
  end

  assign out_valid      = (state_q == FULL);
  assign out_data       = out_data_q;
  assign out_src        = out_src_q;
  assign dbg_state      = state_q;
  assign dbg_last_grant = last_grant_q;

endmodule

// File: tb/tb_rr_arb2_stage.sv
// Directed bench for rr_arb2_stage: reset, single source, contention, backpressure,
// fairness after a solo win, drain to empty, and reset asserted during a stall.
module tb_rr_arb2_stage;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             in0_valid;
  logic [WIDTH-1:0] in0_data;
  logic             in0_ready;
  logic             in1_valid;
  logic [WIDTH-1:0] in1_data;
  logic             in1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
  logic             out_ready;
  logic             dbg_state;
  logic             dbg_last_grant;

  int n_cmp;
  int n_bad;

  // Each entry is {src, data} for the next word expected at the output.
  logic [WIDTH:0] exp_q[$];
  logic [WIDTH:0] exp_w;

  rr_arb2_stage #(.WIDTH(WIDTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .in0_valid      (in0_valid),
    .in0_data       (in0_data),
    .in0_ready      (in0_ready),
    .in1_valid      (in1_valid),
    .in1_data       (in1_data),
    .in1_ready      (in1_ready),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_src        (out_src),
    .out_ready      (out_ready),
    .dbg_state      (dbg_state),
    .dbg_last_grant (dbg_last_grant)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [WIDTH-1:0] d0,
                       input logic v1, input logic [WIDTH-1:0] d1,
                       input logic ordy);
    in0_valid = v0;
    in0_data  = d0;
    in1_valid = v1;
    in1_data  = d1;
    out_ready = ordy;
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [WIDTH-1:0] d,
                           input logic s);
    check({tag, "_valid"}, 32'(out_valid), 32'(v));
    check({tag, "_data"},  32'(out_data),  32'(d));
    check({tag, "_src"},   32'(out_src),   32'(s));
  endtask

  task automatic check_rdy(input string tag, input logic r0, input logic r1);
    check({tag, "_rdy0"}, 32'(in0_ready), 32'(r0));
    check({tag, "_rdy1"}, 32'(in1_ready), 32'(r1));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    drive(1'b1, 8'h99, 1'b1, 8'h98, 1'b1);

    // Reset state, with both sources offering a word.
    cyc();
    check_out("rst", 1'b0, 8'h00, 1'b0);
    check_rdy("rst", 1'b0, 1'b0);
    check("rst_last_grant", 32'(dbg_last_grant), 32'd1);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // Single source: 01, 02, 03 back to back.
    drive(1'b1, 8'h01, 1'b0, 8'h00, 1'b1);
    check_rdy("solo0_a", 1'b1, 1'b0);
    cyc();
    drive(1'b1, 8'h02, 1'b0, 8'h00, 1'b1);
    check_out("solo0_w1", 1'b1, 8'h01, 1'b0);
    check_rdy("solo0_b", 1'b1, 1'b0);
    cyc();
    drive(1'b1, 8'h03, 1'b0, 8'h00, 1'b1);
    check_out("solo0_w2", 1'b1, 8'h02, 1'b0);
    cyc();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    check_out("solo0_w3", 1'b1, 8'h03, 1'b0);
    check_rdy("idle", 1'b0, 1'b0);

    // Drain to empty: out_valid drops, the data register keeps its last word.
    cyc();
    check_out("drain", 1'b0, 8'h03, 1'b0);
    check("drain_state", 32'(dbg_state), 32'd0);

    // Fairness after a solo win: in1 wins alone, then in0 wins the contention.
    drive(1'b0, 8'h00, 1'b1, 8'h11, 1'b1);
    check_rdy("solo1", 1'b0, 1'b1);
    cyc();
    drive(1'b1, 8'hA0, 1'b1, 8'hB0, 1'b1);
    check_out("solo1_w", 1'b1, 8'h11, 1'b1);
    check("solo1_last_grant", 32'(dbg_last_grant), 32'd1);
    check_rdy("fair", 1'b1, 1'b0);

    // Continuous contention alternates 0,1,0,1.
    exp_q.push_back({1'b0, 8'hA0});
    exp_q.push_back({1'b1, 8'hB0});
    exp_q.push_back({1'b0, 8'hA0});
    exp_q.push_back({1'b1, 8'hB0});
    for (int i = 0; i < 4; i++) begin
      cyc();
      exp_w = exp_q.pop_front();
      check("cont_valid", 32'(out_valid), 32'd1);
      check("cont_word", 32'({out_src, out_data}), 32'(exp_w));
      if (i < 3) check_rdy("cont", exp_w[WIDTH], ~exp_w[WIDTH]);
    end

    // Backpressure: load 33, stall 3 cycles with 44 waiting, then drain and fill together.
    drive(1'b1, 8'h33, 1'b0, 8'h00, 1'b1);
    cyc();
    drive(1'b1, 8'h44, 1'b0, 8'h00, 1'b0);
    check_out("bp_load", 1'b1, 8'h33, 1'b0);
    check_rdy("bp_load", 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_out("bp_stall", 1'b1, 8'h33, 1'b0);
      check_rdy("bp_stall", 1'b0, 1'b0);
    end
    drive(1'b1, 8'h44, 1'b0, 8'h00, 1'b1);
    check_rdy("bp_release", 1'b1, 1'b0);
    cyc();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    check_out("bp_fill", 1'b1, 8'h44, 1'b0);
    cyc();
    check_out("bp_drain", 1'b0, 8'h44, 1'b0);

    // Reset asserted mid-stall while holding 5A. last_grant is 0 at that point,
    // so in0 winning afterwards shows that reset restored last_grant to 1.
    drive(1'b1, 8'h5A, 1'b0, 8'h00, 1'b0);
    cyc();
    drive(1'b1, 8'h66, 1'b1, 8'h77, 1'b0);
    check_out("stall_5a", 1'b1, 8'h5A, 1'b0);
    check("stall_last_grant", 32'(dbg_last_grant), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check_out("async_rst", 1'b0, 8'h00, 1'b0);
    check_rdy("async_rst", 1'b0, 1'b0);
    cyc();
    rst = 1'b0;
    drive(1'b1, 8'h66, 1'b1, 8'h77, 1'b1);
    check_rdy("post_rst", 1'b1, 1'b0);
    cyc();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    check_out("post_rst_w", 1'b1, 8'h66, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
